// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq
//
// Sequential BCD-to-binary converter for the calculator datapath. A packed
// DIGITS-digit BCD operand is converted to a BIN_W-bit binary value with
// reverse double-dabble, one result bit per clock. Operands that contain a
// nibble above 9 are rejected immediately with err set and a zero result.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request a conversion of bcd_in (only honoured in IDLE)
//   clear    synchronous abort: back to IDLE, results zeroed
//   bcd_in   packed BCD operand, digit 0 in [3:0]
//   ready    high while IDLE
//   busy     high while converting
//   done     one-cycle pulse when bin_out/err are valid
//   err      last accepted operand contained a non-decimal nibble
//   bin_out  converted value, held until the next accepted start or clear

module bcd_to_binary_seq #(
  parameter int DIGITS = 5,
  parameter int BIN_W  = 17
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                clear,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [BIN_W-1:0]    bin_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int TOT_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [BCD_W-1:0]   bcd_r;
  logic [BIN_W-1:0]   bin_r;
  logic [CNT_W-1:0]   cnt;
  logic [TOT_W-1:0]   shifted;
  logic [BCD_W-1:0]   bcd_next;
  logic [BIN_W-1:0]   bin_next;
  logic               in_bad;
  logic               last_iter;

  // Any nibble above 9 sends the operand down the error path.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  // One reverse double-dabble step: shift the whole register right, then
  // pull 3 out of every BCD nibble that landed at 8 or above. Nibbles are
  // corrected independently, with no borrow between them.
  always_comb begin
    shifted  = {bcd_r, bin_r} >> 1;
    bcd_next = shifted[TOT_W-1 -: BCD_W];
    bin_next = shifted[BIN_W-1:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_next[4*i +: 4] >= 4'd8) bcd_next[4*i +: 4] = bcd_next[4*i +: 4] - 4'd3;
    end
  end

  assign last_iter = (cnt == CNT_W'(BIN_W - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; clear overrides everything else.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = in_bad ? DONE : CONV;
      CONV: if (last_iter) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // Working register, iteration counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_r   <= '0;
      bin_r   <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      bin_out <= '0;
    end else if (clear) begin
      bcd_r   <= '0;
      bin_r   <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      bin_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            bcd_r <= bcd_in;
            bin_r <= '0;
            cnt   <= '0;
            err   <= in_bad;
            if (in_bad) bin_out <= '0;
          end
        end
        CONV: begin
          bcd_r <= bcd_next;
          bin_r <= bin_next;
          cnt   <= cnt + CNT_W'(1);
          if (last_iter) bin_out <= bin_next;
        end
        default: begin
        end
      endcase
    end
  end

  // State decodes; done is a registered signal because state is.
  assign ready = (state == IDLE);
  assign busy  = (state == CONV);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb_bcd_to_binary_seq
//
// Directed bench for bcd_to_binary_seq. Inputs are driven 1 ns after each
// rising edge and outputs are checked at the same point, so every check
// sees the state left by the preceding edge.

module tb_bcd_to_binary_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clear;
  logic [19:0] bcd_in;
  logic        ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [16:0] bin_out;

  int tests_run;
  int tests_failed;

  bcd_to_binary_seq #(
    .DIGITS(5),
    .BIN_W (17)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .clear  (clear),
    .bcd_in (bcd_in),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .bin_out(bin_out)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic c, input logic [19:0] b);
    start  = s;
    clear  = c;
    bcd_in = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Full valid conversion: start sampled at the next edge k, busy through
  // k+16, done/bin_out at k+17, ready again at k+18.
  task automatic runConversion(input string tag, input logic [19:0] bcd, input logic [16:0] expected);
    int dones;
    dones = 0;
    applyStimulus(1'b1, 1'b0, bcd);
    tick();
    applyStimulus(1'b0, 1'b0, 20'h0);
    for (int j = 0; j < 17; j++) begin
      if (busy !== 1'b1 || done !== 1'b0) dones += 100;
      if (j > 0) tick();
    end
    checkOutput({tag, "_busy_window"}, 32'(dones), 32'd0);
    tick();
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_bin"}, 32'(bin_out), 32'(expected));
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_busy_off"}, 32'(busy), 32'd0);
    tick();
    checkOutput({tag, "_ready_after"}, 32'(ready), 32'd1);
    checkOutput({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dones;
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 20'h0);

    // Reset values while rst_n is held low.
    #12;
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_bin", 32'(bin_out), 32'd0);
    tick();
    rst_n = 1'b1;

    // Largest operand, typical operand, zero.
    runConversion("max", 20'h99999, 17'h1869F);
    runConversion("12345", 20'h12345, 17'h03039);
    runConversion("zero", 20'h00000, 17'h00000);

    // Non-decimal nibble: immediate done with err, no busy.
    applyStimulus(1'b1, 1'b0, 20'h1A000);
    tick();
    applyStimulus(1'b0, 1'b0, 20'h0);
    checkOutput("bad_done", 32'(done), 32'd1);
    checkOutput("bad_err", 32'(err), 32'd1);
    checkOutput("bad_bin", 32'(bin_out), 32'd0);
    checkOutput("bad_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("bad_ready", 32'(ready), 32'd1);
    checkOutput("bad_err_held", 32'(err), 32'd1);

    // Clear together with start on the 8th busy cycle aborts the conversion.
    runConversion("pre_clear", 20'h00021, 17'd21);
    applyStimulus(1'b1, 1'b0, 20'h00512);
    tick();
    applyStimulus(1'b0, 1'b0, 20'h0);
    for (int j = 1; j < 8; j++) tick();
    checkOutput("clr_busy_before", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b1, 20'h00512);
    tick();
    applyStimulus(1'b0, 1'b0, 20'h0);
    checkOutput("clr_ready", 32'(ready), 32'd1);
    checkOutput("clr_bin", 32'(bin_out), 32'd0);
    checkOutput("clr_err", 32'(err), 32'd0);
    dones = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checkOutput("clr_no_done", 32'(dones), 32'd0);
    runConversion("after_clear", 20'h00512, 17'h00200);

    // Starts during CONV are ignored and never queued.
    applyStimulus(1'b1, 1'b0, 20'h00007);
    tick();
    applyStimulus(1'b0, 1'b0, 20'h0);
    dones = 0;
    for (int j = 1; j <= 21; j++) begin
      if (j == 2 || j == 15) applyStimulus(1'b1, 1'b0, 20'h99999);
      else                   applyStimulus(1'b0, 1'b0, 20'h0);
      tick();
      if (done === 1'b1) dones++;
      if (j == 17) begin
        checkOutput("ign_done_cycle", 32'(done), 32'd1);
        checkOutput("ign_bin", 32'(bin_out), 32'd7);
      end
      if (j == 18) checkOutput("ign_ready", 32'(ready), 32'd1);
    end
    checkOutput("ign_one_done", 32'(dones), 32'd1);
    checkOutput("ign_bin_held", 32'(bin_out), 32'd7);

    // Asynchronous reset mid-cycle during CONV.
    applyStimulus(1'b1, 1'b0, 20'h12345);
    tick();
    applyStimulus(1'b0, 1'b0, 20'h0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_ready", 32'(ready), 32'd1);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_bin", 32'(bin_out), 32'd0);
    checkOutput("arst_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    runConversion("after_reset", 20'h65535, 17'h0FFFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
